aes_spi_slave: RTL and testbench

//  Serial-side responder for the AES SPI link: the device end the SPI master talks to.

---
 rtl/aes_spi_slave_pkg.sv | 25 ++
 rtl/aes_spi_slave.sv | 168 ++++++++++++++++
 tb/tb_aes_spi_slave.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_spi_slave_pkg.sv
// ----------------------------------------------------------------------------
// aes_spi_slave_pkg
//   Shared definitions for the AES SPI slave: the fixed block width, the
//   controller state encoding and the frame-length helper.
// ----------------------------------------------------------------------------
package aes_spi_slave_pkg;

    // AES block width; the link always carries exactly one block each way.
    localparam int unsigned DATA_W = 128;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        START,
        WAIT,
        TX,
        DONE
    } state_e;

    // Frame = op bit + data block + key (nk 32-bit words).
    function automatic int unsigned frame_len(input int unsigned nk);
        return 1 + DATA_W + nk * 32;
    endfunction

endpackage

// File: rtl/aes_spi_slave.sv
// ----------------------------------------------------------------------------
// aes_spi_slave
//   Device-side responder of the AES SPI link. Receives an op bit, a 128-bit
//   block and an Nk*32-bit key on mosi, launches the external AES core, then
//   streams the 128-bit core result back on miso and pulses done_enc/done_dec.
//
// Ports
//   clk          forwarded SPI bit clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   cs_n         frame select, active low
//   mosi         serial in, MSB first
//   miso         serial out, MSB first
//   miso_valid   high on every cycle miso carries a result bit
//   busy         high from the first frame bit until the done pulse
//   done_enc     one-cycle pulse after an encrypt result is shifted out
//   done_dec     one-cycle pulse after a decrypt result is shifted out
//   core_start   one-cycle launch pulse to the AES core
//   core_dec     0 = encrypt, 1 = decrypt
//   core_data    block presented to the core
//   core_key     key presented to the core
//   core_done    core result valid, only honoured while waiting on the core
//   core_result  core output, captured on core_done
// ----------------------------------------------------------------------------
module aes_spi_slave
    import aes_spi_slave_pkg::*;
#(
    parameter int unsigned Nk = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs_n,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_valid,
    output logic                busy,
    output logic                done_enc,
    output logic                done_dec,
    output logic                core_start,
    output logic                core_dec,
    output logic [DATA_W-1:0]   core_data,
    output logic [Nk*32-1:0]    core_key,
    input  logic                core_done,
    input  logic [DATA_W-1:0]   core_result
);

    localparam int unsigned KEY_W = Nk * 32;
    localparam int unsigned RX_W  = DATA_W + KEY_W;
    localparam int unsigned FRAME = frame_len(Nk);
    localparam int unsigned CNT_W = $clog2(FRAME);

    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               op_q,    op_d;
    logic [RX_W-1:0]    rx_q,    rx_d;
    logic [DATA_W-1:0]  tx_q,    tx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            rx_q    <= '0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        miso       = 1'b0;
        miso_valid = 1'b0;
        busy       = 1'b0;
        done_enc   = 1'b0;
        done_dec   = 1'b0;
        core_start = 1'b0;

        case (state_q)
            IDLE: begin
                // The op bit is the first frame bit and is taken here, so
                // the RX count starts at one.
                if (!cs_n) begin
                    op_d    = mosi;
                    rx_d    = '0;
                    cnt_d   = CNT_ONE;
                    state_d = RX;
                end
            end

            RX: begin
                busy = 1'b1;
                if (cs_n) begin
                    // Early deselect: drop the partial frame entirely.
                    op_d    = 1'b0;
                    rx_d    = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    rx_d = {rx_q[RX_W-2:0], mosi};
                    if (cnt_q == RX_LAST) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            START: begin
                busy       = 1'b1;
                core_start = 1'b1;
                state_d    = WAIT;
            end

            WAIT: begin
                busy = 1'b1;
                if (core_done) begin
                    tx_d    = core_result;
                    cnt_d   = '0;
                    state_d = TX;
                end
            end

            TX: begin
                busy       = 1'b1;
                miso       = tx_q[DATA_W-1];
                miso_valid = 1'b1;
                tx_d       = {tx_q[DATA_W-2:0], 1'b0};
                if (cnt_q == TX_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            DONE: begin
                done_enc = ~op_q;
                done_dec = op_q;
                state_d  = IDLE;
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // The RX register holds {data, key}; it is frozen from START until the
    // next frame begins, which keeps the core inputs stable while waiting.
    assign core_dec  = op_q;
    assign core_data = rx_q[RX_W-1 -: DATA_W];
    assign core_key  = rx_q[KEY_W-1:0];

endmodule

// File: tb/tb_aes_spi_slave.sv
module tb_aes_spi_slave;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT8  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KEY4 = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct {
        int unsigned inst;
        logic        op;
        logic [127:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs_n_a [2];
    logic mosi_a [2];

    exp_t        exp_q [$];
    int unsigned n_checks    = 0;
    int unsigned n_fail      = 0;
    int unsigned done_cnt    = 0;
    int unsigned starts_seen = 0;
    int unsigned starts_exp  = 0;
    int unsigned cyc         = 0;
    int unsigned first_cyc [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural AES stand-in: the FIPS-197 vectors are answered exactly,
    // any other input gets an arbitrary but deterministic transform.
    function automatic logic [127:0] ref_aes(input logic op, input logic [127:0] d,
                                             input logic [255:0] k, input int unsigned nk);
        if (nk == 8 && k == KEY8) begin
            if (!op && d == PT)  return CT8;
            if (op  && d == CT8) return PT;
        end
        if (nk == 4 && k == {128'h0, KEY4}) begin
            if (!op && d == PT)  return CT4;
            if (op  && d == CT4) return PT;
        end
        return {d[114:0], d[127:115]} ^ k[255:128] ^ k[127:0] ^ {128{op}};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned NK   = (g == 0) ? 8 : 4;
        localparam int unsigned FLEN = 1 + 128 + NK * 32;

        logic              miso, miso_valid, busy, done_enc, done_dec;
        logic              core_start, core_dec;
        logic [127:0]      core_data;
        logic [NK*32-1:0]  core_key;
        logic              core_done   = 1'b0;
        logic [127:0]      core_result = '0;

        aes_spi_slave #(.Nk(NK)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .cs_n       (cs_n_a[g]),
            .mosi       (mosi_a[g]),
            .miso       (miso),
            .miso_valid (miso_valid),
            .busy       (busy),
            .done_enc   (done_enc),
            .done_dec   (done_dec),
            .core_start (core_start),
            .core_dec   (core_dec),
            .core_data  (core_data),
            .core_key   (core_key),
            .core_done  (core_done),
            .core_result(core_result)
        );

        // AES core model: 14-cycle latency, random noise on core_result and
        // stray core_done pulses whenever no operation is outstanding.
        logic          pend = 1'b0;
        int unsigned   wcnt = 0;
        logic          snap_dec;
        logic [127:0]  snap_data;
        logic [255:0]  snap_key;

        always @(negedge clk) begin
            #1;
            core_done   = 1'b0;
            core_result = rnd128();
            if (rst) begin
                pend = 1'b0;
            end else if (pend) begin
                wcnt++;
                if (wcnt == 1) chk("start_one_cycle", core_start, 0);
                if (wcnt == 14) begin
                    chk("core_inputs_stable", {core_dec, core_data, 256'(core_key)},
                        {snap_dec, snap_data, snap_key});
                    core_done   = 1'b1;
                    core_result = ref_aes(snap_dec, snap_data, snap_key, NK);
                    pend        = 1'b0;
                end
            end else if (core_start) begin
                starts_seen++;
                chk("start_latency", cyc - first_cyc[g], FLEN);
                pend      = 1'b1;
                wcnt      = 0;
                snap_dec  = core_dec;
                snap_data = core_data;
                snap_key  = 256'(core_key);
            end else begin
                core_done = ($urandom_range(0, 7) == 0);
            end
        end

        // Result monitor: gathers miso bits and checks them at the done pulse.
        int unsigned   bits_seen = 0;
        logic [127:0]  col = '0;

        always @(negedge clk) begin
            exp_t e;
            if (miso_valid) begin
                if (bits_seen == 0) chk("busy_in_tx", busy, 1);
                col = {col[126:0], miso};
                bits_seen++;
            end
            if (done_enc || done_dec) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_inst", g, e.inst);
                    chk("result", col, e.res);
                    chk("done_kind", {done_enc, done_dec}, e.op ? 2'b01 : 2'b10);
                    chk("tx_bit_count", bits_seen, 128);
                    chk("done_idle_outs", {busy, miso, miso_valid}, 3'b000);
                end
                bits_seen = 0;
                done_cnt++;
            end else if (!busy) begin
                bits_seen = 0;
            end
        end
    end

    task automatic send_frame(input int unsigned inst, input logic op, input logic [127:0] d,
                              input logic [255:0] k, input int unsigned nbits, input bit hold);
        int unsigned  len;
        logic [384:0] fr;
        len = (inst == 0) ? 385 : 257;
        if (inst == 0) fr = {op, d, k};
        else           fr = {128'h0, op, d, k[127:0]};
        if (nbits == len) starts_exp++;
        for (int unsigned i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (i == 0) first_cyc[inst] = cyc;
            cs_n_a[inst] = 1'b0;
            mosi_a[inst] = fr[len - 1 - i];
        end
        if (!hold) begin
            @(negedge clk);
            cs_n_a[inst] = 1'b1;
            mosi_a[inst] = 1'($urandom);
        end
    endtask

    task automatic run_frame(input int unsigned inst, input logic op, input logic [127:0] d,
                             input logic [255:0] k, input bit hold);
        exp_t        e;
        int unsigned tgt;
        bit          got;
        e.inst = inst;
        e.op   = op;
        e.res  = ref_aes(op, d, k, (inst == 0) ? 8 : 4);
        exp_q.push_back(e);
        tgt = done_cnt + 1;
        send_frame(inst, op, d, k, (inst == 0) ? 385 : 257, hold);
        got = 1'b0;
        for (int unsigned c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= tgt) got = 1'b1;
            else mosi_a[inst] = 1'($urandom);
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_ctrl_outs"}, {g_inst[0].busy, g_inst[0].miso, g_inst[0].miso_valid,
                                  g_inst[0].done_enc, g_inst[0].done_dec,
                                  g_inst[0].core_start, g_inst[0].core_dec}, 0);
        chk({tag, "_core_data"}, g_inst[0].core_data, 0);
        chk({tag, "_core_key"},  g_inst[0].core_key, 0);
    endtask

    initial begin
        bit reached;
        cs_n_a[0] = 1'b1;
        cs_n_a[1] = 1'b1;
        mosi_a[0] = 1'b0;
        mosi_a[1] = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        // FIPS-197 vectors on both key sizes.
        run_frame(0, 1'b0, PT,  KEY8, 1'b0);
        run_frame(0, 1'b1, CT8, KEY8, 1'b0);
        run_frame(1, 1'b0, PT,  {128'h0, KEY4}, 1'b0);
        run_frame(1, 1'b1, CT4, {128'h0, KEY4}, 1'b0);

        // Deselect after 50 bits, then a full frame.
        send_frame(0, 1'b0, rnd128(), {rnd128(), rnd128()}, 50, 1'b0);
        #1 chk("busy_rx", g_inst[0].busy, 1);
        @(negedge clk);
        #1 chk("abort_busy", g_inst[0].busy, 0);
        repeat (10) @(negedge clk);
        run_frame(0, 1'b0, PT, KEY8, 1'b0);

        // Reset while waiting on the core.
        send_frame(0, 1'b1, rnd128(), {rnd128(), rnd128()}, 385, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check_idle_zero("rst_wait");
        run_frame(0, 1'b1, CT8, KEY8, 1'b0);

        // Reset part way through the result shift-out.
        send_frame(0, 1'b0, rnd128(), {rnd128(), rnd128()}, 385, 1'b0);
        reached = 1'b0;
        for (int unsigned c = 0; c < 400 && !reached; c++) begin
            @(negedge clk);
            #1;
            if (g_inst[0].bits_seen == 40) reached = 1'b1;
        end
        if (!reached) chk("tx_bit40_timeout", 0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check_idle_zero("rst_tx");
        run_frame(0, 1'b0, PT, KEY8, 1'b0);

        // cs_n held low across TX/DONE straight into the next frame.
        run_frame(0, 1'b1, rnd128(), {rnd128(), rnd128()}, 1'b1);
        run_frame(0, 1'b0, rnd128(), {rnd128(), rnd128()}, 1'b0);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_frame(0, 1'($urandom), rnd128(), {rnd128(), rnd128()}, 1'b0);
        end
        run_frame(1, 1'($urandom), rnd128(), {128'h0, rnd128()}, 1'b0);

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("core_start_count", starts_seen, starts_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1, "watchdog");
    end

endmodule
